// File: rtl/vid_phy_controller_rx_gearbox_if.sv
// rtl/vid_phy_controller_rx_gearbox_if.sv - data/handshake bundle for the RX gearbox
interface vid_phy_controller_rx_gearbox_if #(
    parameter int CHANNELS  = 3,
    parameter int DW        = 20,
    parameter int RATIO     = 2,
    parameter int FIFO_WRDS = 4
);
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW = $clog2(FIFO_WRDS) + 1;

    // Upstream lane words and control
    logic                         VLD_IN;
    logic [CHANNELS*DW-1:0]       DAT_IN;
    logic                         ALIGN_IN;
    logic                         CLR_IN;
    // Downstream link word handshake and status
    logic                         RDY_IN;
    logic                         VLD_OUT;
    logic [CHANNELS*RATIO*DW-1:0] DAT_OUT;
    logic [PW-1:0]                PH_OUT;
    logic [LW-1:0]                LVL_OUT;
    logic                         OVF_OUT;

    // Driver side (lane data path and link layer)
    modport master (
        output VLD_IN, DAT_IN, ALIGN_IN, CLR_IN, RDY_IN,
        input  VLD_OUT, DAT_OUT, PH_OUT, LVL_OUT, OVF_OUT
    );

    // Gearbox side
    modport slave (
        input  VLD_IN, DAT_IN, ALIGN_IN, CLR_IN, RDY_IN,
        output VLD_OUT, DAT_OUT, PH_OUT, LVL_OUT, OVF_OUT
    );
endinterface

// File: rtl/vid_phy_controller_rx_gearbox.sv
// rtl/vid_phy_controller_rx_gearbox.sv - RATIO:1 word gatherer with FWFT output FIFO
module vid_phy_controller_rx_gearbox #(
    parameter int CHANNELS  = 3,
    parameter int DW        = 20,
    parameter int RATIO     = 2,
    parameter int FIFO_WRDS = 4
) (
    input logic CLK_IN,
    input logic RST_IN,
    vid_phy_controller_rx_gearbox_if.slave bus
);
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW = $clog2(FIFO_WRDS);
    localparam int LW = AW + 1;
    localparam int WW = CHANNELS * RATIO * DW;
    localparam logic [PW-1:0] PH_LAST  = PW'(RATIO - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_WRDS);

    // Assembly state
    logic [PW-1:0] ph_q, ph_d;
    logic [PW-1:0] ph_base;
    logic [WW-1:0] asm_q, asm_d;

    // Output FIFO state; occupancy kept separately from the wrapping pointers
    logic [WW-1:0] mem_q [FIFO_WRDS];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // Next-state: slot write, phase advance, FIFO push/pop arbitration, overflow flag
    always_comb begin
        // ALIGN restarts at slot 0, so the incoming word (if any) lands in slot 0
        // and a partial word that was about to wrap is never pushed.
        ph_base = bus.ALIGN_IN ? '0 : ph_q;

        // Only the addressed slot changes; the rest keep stale data, which is
        // harmless because every slot is rewritten before the next push.
        asm_d = asm_q;
        if (bus.VLD_IN) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < RATIO; k++) begin
                    if (ph_base == PW'(k)) begin
                        asm_d[(c*RATIO+k)*DW +: DW] = bus.DAT_IN[c*DW +: DW];
                    end
                end
            end
        end

        push = bus.VLD_IN && (ph_base == PH_LAST);

        ph_d = ph_base;
        if (bus.VLD_IN) begin
            ph_d = push ? '0 : ph_base + PW'(1);
        end

        pop   = (cnt_q != '0) && bus.RDY_IN;
        full  = (cnt_q == LVL_FULL);
        // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + LW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - LW'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (bus.CLR_IN) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Phase counter and per-channel assembly registers
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            ph_q  <= '0;
            asm_q <= '0;
        end else begin
            ph_q  <= ph_d;
            asm_q <= asm_d;
        end
    end

    // Output FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            for (int i = 0; i < FIFO_WRDS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= asm_d;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.VLD_OUT = (cnt_q != '0);
    assign bus.DAT_OUT = mem_q[rd_ptr_q];
    assign bus.PH_OUT  = ph_q;
    assign bus.LVL_OUT = cnt_q;
    assign bus.OVF_OUT = ovf_q;
endmodule

// File: tb/tb_vid_phy_controller_rx_gearbox.sv
// tb/tb_vid_phy_controller_rx_gearbox.sv - three-configuration bench with queue model
module tb_vid_phy_controller_rx_gearbox;
    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [59:0] dat;
    logic        align;
    logic        clr;
    logic        rdy;
    bit          cmp_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // d0: defaults, d1: 2 lanes x4, d2: 1 lane x1 with a 2-deep FIFO
    vid_phy_controller_rx_gearbox_if #(.CHANNELS(3), .DW(20), .RATIO(2), .FIFO_WRDS(4)) if0 ();
    vid_phy_controller_rx_gearbox_if #(.CHANNELS(2), .DW(20), .RATIO(4), .FIFO_WRDS(4)) if1 ();
    vid_phy_controller_rx_gearbox_if #(.CHANNELS(1), .DW(20), .RATIO(1), .FIFO_WRDS(2)) if2 ();

    assign if0.VLD_IN = vld;  assign if0.DAT_IN = dat[59:0];
    assign if1.VLD_IN = vld;  assign if1.DAT_IN = dat[39:0];
    assign if2.VLD_IN = vld;  assign if2.DAT_IN = dat[19:0];
    assign if0.ALIGN_IN = align; assign if1.ALIGN_IN = align; assign if2.ALIGN_IN = align;
    assign if0.CLR_IN = clr;     assign if1.CLR_IN = clr;     assign if2.CLR_IN = clr;
    assign if0.RDY_IN = rdy;     assign if1.RDY_IN = rdy;     assign if2.RDY_IN = rdy;

    vid_phy_controller_rx_gearbox #(.CHANNELS(3), .DW(20), .RATIO(2), .FIFO_WRDS(4))
        u_dut0 (.CLK_IN(clk), .RST_IN(rst), .bus(if0));
    vid_phy_controller_rx_gearbox #(.CHANNELS(2), .DW(20), .RATIO(4), .FIFO_WRDS(4))
        u_dut1 (.CLK_IN(clk), .RST_IN(rst), .bus(if1));
    vid_phy_controller_rx_gearbox #(.CHANNELS(1), .DW(20), .RATIO(1), .FIFO_WRDS(2))
        u_dut2 (.CLK_IN(clk), .RST_IN(rst), .bus(if2));

    logic [159:0] o_dat [3];
    logic [159:0] o_ph  [3];
    logic [159:0] o_lvl [3];
    logic         o_vld [3];
    logic         o_ovf [3];
    assign o_dat[0] = 160'(if0.DAT_OUT); assign o_dat[1] = 160'(if1.DAT_OUT); assign o_dat[2] = 160'(if2.DAT_OUT);
    assign o_ph[0]  = 160'(if0.PH_OUT);  assign o_ph[1]  = 160'(if1.PH_OUT);  assign o_ph[2]  = 160'(if2.PH_OUT);
    assign o_lvl[0] = 160'(if0.LVL_OUT); assign o_lvl[1] = 160'(if1.LVL_OUT); assign o_lvl[2] = 160'(if2.LVL_OUT);
    assign o_vld[0] = if0.VLD_OUT; assign o_vld[1] = if1.VLD_OUT; assign o_vld[2] = if2.VLD_OUT;
    assign o_ovf[0] = if0.OVF_OUT; assign o_ovf[1] = if1.OVF_OUT; assign o_ovf[2] = if2.OVF_OUT;

    // Model: collected words per slot, a queue of finished link words, sticky flag
    int           cfg_ch  [3] = '{3, 2, 1};
    int           cfg_r   [3] = '{2, 4, 1};
    int           cfg_dep [3] = '{4, 4, 2};
    int           m_ph    [3];
    logic [59:0]  m_w     [3][8];
    logic [159:0] m_q     [3][$];
    bit           m_ovf   [3];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int           p;
            int           sz;
            bit           psh;
            bit           pp;
            logic [159:0] w;
            if (rst) begin
                m_ph[d] = 0;
                m_q[d].delete();
                m_ovf[d] = 1'b0;
            end else begin
                psh = 1'b0;
                w   = '0;
                pp  = (m_q[d].size() != 0) && rdy;
                p   = align ? 0 : m_ph[d];
                if (vld) begin
                    m_w[d][p] = dat;
                    if (p == cfg_r[d] - 1) begin
                        psh = 1'b1;
                        for (int c = 0; c < cfg_ch[d]; c++)
                            for (int k = 0; k < cfg_r[d]; k++)
                                w[(c*cfg_r[d]+k)*20 +: 20] = m_w[d][k][c*20 +: 20];
                        p = 0;
                    end else begin
                        p = p + 1;
                    end
                end
                m_ph[d] = p;
                sz = m_q[d].size();
                if (pp) void'(m_q[d].pop_front());
                if (clr) m_ovf[d] = 1'b0;
                if (psh) begin
                    if (sz == cfg_dep[d] && !pp) m_ovf[d] = 1'b1;
                    else m_q[d].push_back(w);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic in_word(input logic [59:0] w);
        vld = 1'b1;
        dat = w;
        step();
        vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [59:0] mk(input int x);
        return {20'h0, 20'(x + 256), 20'(x)};
    endfunction

    // Every-cycle comparison of all three DUTs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("d%0d_vld", d), 160'(o_vld[d]), 160'(m_q[d].size() != 0));
                check($sformatf("d%0d_lvl", d), o_lvl[d], 160'(m_q[d].size()));
                check($sformatf("d%0d_ph", d), o_ph[d], 160'(m_ph[d]));
                check($sformatf("d%0d_ovf", d), 160'(o_ovf[d]), 160'(m_ovf[d]));
                if (m_q[d].size() != 0)
                    check($sformatf("d%0d_dat", d), o_dat[d], m_q[d][0]);
            end
        end
    end

    initial begin
        rst = 1'b1; vld = 1'b0; dat = '0; align = 1'b0; clr = 1'b0; rdy = 1'b0;
        step();
        step();
        check("rst_vld", 160'(o_vld[0]), 160'(0));
        check("rst_dat0", o_dat[0], 160'(0));
        check("rst_dat1", o_dat[1], 160'(0));
        check("rst_ph", o_ph[0], 160'(0));
        check("rst_lvl", o_lvl[0], 160'(0));
        check("rst_ovf", 160'(o_ovf[0]), 160'(0));
        rst = 1'b0;
        cmp_en = 1'b1;

        // Basic two-word assembly on the default configuration
        in_word(60'h1);
        check("t1_ph1", o_ph[0], 160'(1));
        check("t1_vld_early", 160'(o_vld[0]), 160'(0));
        in_word(60'h2);
        check("t1_vld", 160'(o_vld[0]), 160'(1));
        check("t1_dat", o_dat[0], 160'(120'h0000200001));
        check("t1_lvl", o_lvl[0], 160'(1));

        // Reset with a partial word and three entries queued
        for (int j = 3; j <= 7; j++) in_word(60'(j));
        check("t6_lvl3", o_lvl[0], 160'(3));
        check("t6_ph1", o_ph[0], 160'(1));
        check("t6_d2_ovf_pre", 160'(o_ovf[2]), 160'(1));
        do_reset();
        check("t6_vld", 160'(o_vld[0]), 160'(0));
        check("t6_lvl", o_lvl[0], 160'(0));
        check("t6_ph", o_ph[0], 160'(0));
        check("t6_dat", o_dat[0], 160'(0));
        check("t6_d2_ovf", 160'(o_ovf[2]), 160'(0));
        in_word(60'h11);
        in_word(60'h22);
        check("t6_clean", o_dat[0], 160'(120'h0002200011));
        check("t6_clean_lvl", o_lvl[0], 160'(1));

        // Realignment on the 4:1 two-lane configuration
        do_reset();
        check("t2_ph0", o_ph[1], 160'(0));
        in_word(mk(10)); check("t2_ph_a", o_ph[1], 160'(1));
        in_word(mk(11)); check("t2_ph_b", o_ph[1], 160'(2));
        align = 1'b1;
        in_word(mk(12)); check("t2_ph_c", o_ph[1], 160'(1));
        align = 1'b0;
        in_word(mk(13)); check("t2_ph_d", o_ph[1], 160'(2));
        in_word(mk(14)); check("t2_ph_e", o_ph[1], 160'(3));
        in_word(mk(15)); check("t2_ph_f", o_ph[1], 160'(0));
        check("t2_dat", o_dat[1], {20'h0010F, 20'h0010E, 20'h0010D, 20'h0010C,
                                   20'h0000F, 20'h0000E, 20'h0000D, 20'h0000C});
        check("t2_lvl", o_lvl[1], 160'(1));

        // Overflow with RDY low, clear, then drain in order
        do_reset();
        rdy = 1'b0;
        for (int j = 1; j <= 10; j++) in_word(60'(j));
        check("t3_lvl", o_lvl[0], 160'(4));
        check("t3_ovf", 160'(o_ovf[0]), 160'(1));
        check("t3_head", o_dat[0], 160'(120'h0000200001));
        clr = 1'b1; step(); clr = 1'b0;
        check("t3_clr", 160'(o_ovf[0]), 160'(0));
        rdy = 1'b1;
        step();
        check("t3_head2", o_dat[0], 160'(120'h0000400003));
        step(); step(); step();
        check("t3_empty_lvl", o_lvl[0], 160'(0));
        check("t3_empty_vld", 160'(o_vld[0]), 160'(0));
        rdy = 1'b0;

        // Full FIFO with a simultaneous pop and push, then clear racing a drop
        for (int j = 21; j <= 29; j++) in_word(60'(j));
        rdy = 1'b1;
        in_word(60'(30));
        rdy = 1'b0;
        check("t4_lvl", o_lvl[0], 160'(4));
        check("t4_ovf", 160'(o_ovf[0]), 160'(0));
        check("t4_head", o_dat[0], 160'(120'h0001800017));
        clr = 1'b1;
        in_word(60'(31));
        in_word(60'(32));
        clr = 1'b0;
        check("t4_setwins", 160'(o_ovf[0]), 160'(1));
        rdy = 1'b1;
        step(); step(); step();
        check("t4_tail", o_dat[0], 160'(120'h0001E0001D));
        step();
        rdy = 1'b0;

        // 1:1 configuration with gapped valid
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_word(60'(32'h100 + i));
            check("t5_vld", 160'(o_vld[2]), 160'(1));
            check("t5_dat", o_dat[2], 160'(20'(32'h100 + i)));
            check("t5_ph", o_ph[2], 160'(0));
            step();
            check("t5_popped", 160'(o_vld[2]), 160'(0));
            step();
        end

        // Mixed traffic, model comparison only
        for (int i = 0; i < 400; i++) begin
            vld   = ($urandom % 4) != 0;
            dat   = {$urandom, $urandom};
            align = ($urandom % 16) == 0;
            clr   = ($urandom % 10) == 0;
            rdy   = ($urandom % 2) == 0;
            rst   = ($urandom % 97) == 0;
            step();
        end
        vld = 1'b0; align = 1'b0; clr = 1'b0; rst = 1'b0;
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
